// File: rtl/wm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wm_pkg
//  Brief    : Shared types and default constants for the washing-machine
//             button conditioner (debounce state encoding, default timing).
//  Revision : 1.0  initial release
// ============================================================================
package wm_pkg;

   // Debounce FSM encoding; values are fixed so state dumps stay readable.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      CHK_HI  = 2'b01,
      PRESSED = 2'b10,
      CHK_LO  = 2'b11
   } db_state_t;

   localparam int C_SYNC_STAGES     = 2;
   localparam int C_DEBOUNCE_CYCLES = 8;
   localparam int C_CNT_W           = 4;

endpackage : wm_pkg
`default_nettype wire

// File: rtl/wm_button_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : wm_button_conditioner_if
//  Brief    : Button-side and FSM-side signals of the button conditioner.
//             master = stimulus/FSM side, slave = conditioner.
//  Revision : 1.0  initial release
// ============================================================================
interface wm_button_conditioner_if;

   logic start_raw;
   logic pause_raw;
   logic cycle_done;
   logic start_button;
   logic pause_button;
   logic start_pulse;
   logic pause_pulse;

   modport master (
      output start_raw,
      output pause_raw,
      output cycle_done,
      input  start_button,
      input  pause_button,
      input  start_pulse,
      input  pause_pulse
   );

   modport slave (
      input  start_raw,
      input  pause_raw,
      input  cycle_done,
      output start_button,
      output pause_button,
      output start_pulse,
      output pause_pulse
   );

endinterface : wm_button_conditioner_if
`default_nettype wire

// File: rtl/wm_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : wm_debounce
//  Brief    : Synchroniser plus debounce FSM for one push-button. Emits a
//             single-cycle registered pulse per accepted press; releases
//             are debounced but produce no pulse.
//  Revision : 1.0  initial release
// ============================================================================
module wm_debounce
   import wm_pkg::*;
#(
   parameter int SYNC_STAGES     = C_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
   parameter int CNT_W           = C_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_pulse
);

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync;
   db_state_t              r_state;
   db_state_t              w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   r_pulse;
   logic                   w_pulse_nxt;

   // Shift the asynchronous button level through the synchroniser chain.
   always_ff @(posedge clk) begin
      if (reset) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

   // State, stability counter and press pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   // Next-state logic: a level must hold DEBOUNCE_CYCLES samples to be accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_sync) begin
               w_state_nxt = CHK_HI;
               w_cnt_nxt   = '0;
            end
         end
         CHK_HI: begin
            if (!w_sync) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == C_CNT_LAST) begin
               w_state_nxt = PRESSED;
               w_cnt_nxt   = '0;
               w_pulse_nxt = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!w_sync) begin
               w_state_nxt = CHK_LO;
               w_cnt_nxt   = '0;
            end
         end
         CHK_LO: begin
            if (w_sync) begin
               w_state_nxt = PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == C_CNT_LAST) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_pulse = r_pulse;

endmodule : wm_debounce
`default_nettype wire

// File: rtl/wm_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : wm_button_conditioner
//  Brief    : Converts raw start/pause push-buttons into clean registered
//             start/pause levels for the wash control FSM; cycle_done from
//             the FSM clears both levels.
//  Revision : 1.0  initial release
// ============================================================================
module wm_button_conditioner
   import wm_pkg::*;
#(
   parameter int SYNC_STAGES     = C_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
   parameter int CNT_W           = C_CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   wm_button_conditioner_if.slave   bus
);

   logic w_start_pulse;
   logic w_pause_pulse;
   logic r_start_button;
   logic r_pause_button;

   wm_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_start_db (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (bus.start_raw),
      .o_pulse (w_start_pulse)
   );

   wm_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_pause_db (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (bus.pause_raw),
      .o_pulse (w_pause_pulse)
   );

   // Run request: set by a start press, cleared by cycle_done (which wins).
   always_ff @(posedge clk) begin
      if (reset)               r_start_button <= 1'b0;
      else if (bus.cycle_done) r_start_button <= 1'b0;
      else if (w_start_pulse)  r_start_button <= 1'b1;
   end

   // Pause toggles only while running; held at 0 when idle or on cycle_done.
   always_ff @(posedge clk) begin
      if (reset)                                  r_pause_button <= 1'b0;
      else if (bus.cycle_done || !r_start_button) r_pause_button <= 1'b0;
      else if (w_pause_pulse)                     r_pause_button <= ~r_pause_button;
   end

   assign bus.start_button = r_start_button;
   assign bus.pause_button = r_pause_button;
   assign bus.start_pulse  = w_start_pulse;
   assign bus.pause_pulse  = w_pause_pulse;

endmodule : wm_button_conditioner
`default_nettype wire

// File: tb/tb_wm_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wm_button_conditioner
//  Brief    : Directed self-checking bench for wm_button_conditioner at
//             default parameters (clock period 50).
//  Revision : 1.0  initial release
// ============================================================================
module tb_wm_button_conditioner;

   logic clk_tb = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #25 clk_tb = ~clk_tb;

   wm_button_conditioner_if bus_if ();

   wm_button_conditioner #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8),
      .CNT_W           (4)
   ) dut (
      .clk   (clk_tb),
      .reset (reset),
      .bus   (bus_if)
   );

   // Single comparison point: counts and reports every check.
   task automatic check(input string tag, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", tag, act, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk_tb);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic sb, input logic pb,
                             input logic sp, input logic pp);
      check({tag, ".start_button"}, bus_if.start_button, sb);
      check({tag, ".pause_button"}, bus_if.pause_button, pb);
      check({tag, ".start_pulse"},  bus_if.start_pulse,  sp);
      check({tag, ".pause_pulse"},  bus_if.pause_pulse,  pp);
   endtask

   // Hold pause for a full press and check the pulse edge and resulting level.
   task automatic pause_press(input string tag, input logic pb_before, input logic pb_after);
      bus_if.pause_raw = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         tick();
         check($sformatf("%s.pulse_e%0d", tag, e), bus_if.pause_pulse, (e == 11));
         check($sformatf("%s.level_e%0d", tag, e), bus_if.pause_button, pb_before);
      end
      tick();
      check({tag, ".pulse_after"}, bus_if.pause_pulse, 1'b0);
      check({tag, ".level_after"}, bus_if.pause_button, pb_after);
      bus_if.pause_raw = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         check($sformatf("%s.release_%0d", tag, i), bus_if.pause_pulse, 1'b0);
         check($sformatf("%s.release_lvl_%0d", tag, i), bus_if.pause_button, pb_after);
      end
   endtask

   initial begin
      reset             = 1'b1;
      bus_if.start_raw  = 1'b1;
      bus_if.pause_raw  = 1'b0;
      bus_if.cycle_done = 1'b0;

      // 1: reset with start held, then held press is accepted at edge 11.
      tick();
      check_outs("t1.rst1", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_outs("t1.rst2", 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      for (int e = 1; e <= 11; e++) begin
         tick();
         check($sformatf("t1.pulse_e%0d", e), bus_if.start_pulse, (e == 11));
         check($sformatf("t1.level_e%0d", e), bus_if.start_button, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t1.hold_pulse_%0d", i), bus_if.start_pulse, 1'b0);
         check($sformatf("t1.hold_level_%0d", i), bus_if.start_button, 1'b1);
      end
      bus_if.start_raw = 1'b0;
      repeat (14) tick();
      bus_if.cycle_done = 1'b1;
      tick();
      bus_if.cycle_done = 1'b0;
      check("t1.done_clears", bus_if.start_button, 1'b0);

      // 2: bounce for 20 cycles, then a clean rise.
      for (int c = 0; c < 20; c++) begin
         bus_if.start_raw = ((c / 2) % 2 == 0);
         tick();
         check($sformatf("t2.bounce_%0d", c), bus_if.start_pulse, 1'b0);
      end
      bus_if.start_raw = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         tick();
         check($sformatf("t2.pulse_e%0d", e), bus_if.start_pulse, (e == 11));
      end
      tick();
      check("t2.level", bus_if.start_button, 1'b1);
      bus_if.start_raw = 1'b0;
      repeat (14) tick();
      bus_if.cycle_done = 1'b1;
      tick();
      bus_if.cycle_done = 1'b0;
      check("t2.done_clears", bus_if.start_button, 1'b0);

      // 3: pause press while idle pulses but leaves pause_button at 0.
      pause_press("t3", 1'b0, 1'b0);

      // 4: run, then pause on, pause off.
      bus_if.start_raw = 1'b1;
      repeat (12) tick();
      check("t4.running", bus_if.start_button, 1'b1);
      bus_if.start_raw = 1'b0;
      repeat (14) tick();
      pause_press("t4.p1", 1'b0, 1'b1);
      pause_press("t4.p2", 1'b1, 1'b0);

      // 5: paused, then cycle_done clears both; start coincident with done.
      pause_press("t5.p", 1'b0, 1'b1);
      bus_if.cycle_done = 1'b1;
      tick();
      bus_if.cycle_done = 1'b0;
      check_outs("t5.done", 1'b0, 1'b0, 1'b0, 1'b0);
      bus_if.start_raw = 1'b1;
      repeat (11) tick();
      check("t5.start_pulse", bus_if.start_pulse, 1'b1);
      bus_if.cycle_done = 1'b1;
      tick();
      bus_if.cycle_done = 1'b0;
      check("t5.done_wins", bus_if.start_button, 1'b0);
      tick();
      check("t5.stays_idle", bus_if.start_button, 1'b0);
      bus_if.start_raw = 1'b0;
      repeat (14) tick();

      // 6: reset in the middle of press qualification; no stray pulse later.
      bus_if.start_raw = 1'b1;
      repeat (8) tick();
      reset = 1'b1;
      tick();
      check_outs("t6.rst", 1'b0, 1'b0, 1'b0, 1'b0);
      bus_if.start_raw = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         check($sformatf("t6.no_pulse_%0d", i), bus_if.start_pulse, 1'b0);
         check($sformatf("t6.no_level_%0d", i), bus_if.start_button, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_wm_button_conditioner
`default_nettype wire
